// File: rtl/srec_loader.sv
// srec_loader: streaming Motorola S-record decoder that turns S1/S2/S3 data bytes into byte writes.
// Define SREC_CHECKSUM_EN to verify record checksums; otherwise checksum nibbles are only hex-checked.
module srec_loader #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] ADDR_OFFSET = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic              mem_write,
  output logic [1:0]        mem_access_size,
  output logic [31:0]       entry_point,
  output logic [CNT_W-1:0]  rec_count,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);
  localparam logic [3:0] IDLE = 4'd0, TYPE = 4'd1, COUNT = 4'd2, ADDR = 4'd3, DATA = 4'd4,
                         WRITE = 4'd5, CSUM = 4'd6, EOL = 4'd7, SKIP = 4'd8, DONE = 4'd9;
  logic [3:0] state, rec_type, hnib, nib;
  logic [2:0] addr_len, abytes, tlen;
  logic [7:0] count, data_left, byte_w;
  logic [31:0] rec_addr;
  logic [ADDR_W-1:0] offset;
  logic half, xfer, take, is_cr, is_lf, is_dig, is_hex, in_field, is_data, is_term, csum_bad;
  logic [1:0] ecode;
  assign mem_access_size = 2'b00;
  assign char_ready = state != WRITE && state != DONE;
  always_comb begin
    xfer = char_valid && char_ready;
    is_cr = char_in == 8'h0d;
    is_lf = char_in == 8'h0a;
    is_dig = char_in >= 8'h30 && char_in <= 8'h39;
    is_hex = is_dig || (char_in >= 8'h41 && char_in <= 8'h46) || (char_in >= 8'h61 && char_in <= 8'h66);
    nib = is_dig ? char_in[3:0] : char_in[3:0] + 4'd9;
    byte_w = {hnib, nib};
    tlen = (char_in[3:0] inside {4'd0, 4'd1, 4'd5, 4'd9}) ? 3'd2 :
           (char_in[3:0] inside {4'd2, 4'd8}) ? 3'd3 :
           (char_in[3:0] inside {4'd3, 4'd7}) ? 3'd4 : 3'd0;
    in_field = state inside {COUNT, ADDR, DATA, CSUM};
    is_data = rec_type inside {4'd1, 4'd2, 4'd3};
    is_term = rec_type inside {4'd7, 4'd8, 4'd9};
    ecode = (!xfer || is_cr) ? 2'b00 :
            (state == IDLE) ? ((is_lf || char_in == 8'h53) ? 2'b00 : 2'b01) :
            (state == TYPE) ? (is_lf ? 2'b10 : (is_dig && tlen != 3'd0) ? 2'b00 : 2'b01) :
            in_field ? (is_lf ? 2'b10 : !is_hex ? 2'b01 :
                        (state == COUNT && half && byte_w <= {5'd0, addr_len}) ? 2'b10 : 2'b00) :
            (state == EOL && is_lf && csum_bad) ? 2'b11 : 2'b00;
    take = xfer && !is_cr && ecode == 2'b00;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE; rec_type <= '0; hnib <= '0; half <= 1'b0; addr_len <= '0; abytes <= '0;
      count <= '0; data_left <= '0; rec_addr <= '0; offset <= '0;
      mem_address <= '0; mem_data_in <= '0; mem_write <= 1'b0;
      entry_point <= '0; rec_count <= '0; done <= 1'b0; err <= 1'b0; err_code <= 2'b00;
    end else begin
      mem_write <= 1'b0;
      if (ecode != 2'b00 && !err) begin
        err <= 1'b1;
        err_code <= ecode;
      end
      if (state == WRITE) begin
        offset <= offset + ADDR_W'(1);
        state <= data_left == 8'd0 ? CSUM : DATA;
      end else if (ecode != 2'b00) begin
        state <= is_lf ? IDLE : SKIP;
      end else if (take) begin
        if (in_field) begin
          half <= !half;
          hnib <= nib;
        end
        case (state)
          IDLE: state <= is_lf ? IDLE : TYPE;
          TYPE: begin
            rec_type <= char_in[3:0]; addr_len <= tlen; rec_addr <= '0; offset <= '0;
            half <= 1'b0; state <= COUNT;
          end
          COUNT: if (half) begin
            count <= byte_w; abytes <= addr_len; state <= ADDR;
          end
          ADDR: if (half) begin
            rec_addr <= {rec_addr[23:0], byte_w};
            abytes <= abytes - 3'd1;
            data_left <= count - {5'd0, addr_len} - 8'd1;
            if (abytes == 3'd1) state <= (count == {5'd0, addr_len} + 8'd1) ? CSUM : DATA;
          end
          DATA: if (half) begin
            data_left <= data_left - 8'd1;
            if (is_data) begin
              mem_address <= rec_addr[ADDR_W-1:0] + ADDR_OFFSET + offset;
              mem_data_in <= {24'h0, byte_w};
              mem_write <= 1'b1;
              state <= WRITE;
            end else if (data_left == 8'd1) state <= CSUM;
          end
          CSUM: if (half) state <= EOL;
          EOL: if (is_lf) begin
            if (is_data && ~&rec_count) rec_count <= rec_count + CNT_W'(1);
            if (is_term) begin
              entry_point <= rec_addr; done <= 1'b1;
            end
            state <= is_term ? DONE : IDLE;
          end
          SKIP: if (is_lf) state <= IDLE;
          default: ;
        endcase
      end
    end
`ifdef SREC_CHECKSUM_EN
  logic [7:0] sum;
  // running sum of count, address and data bytes; a record is good when checksum == ~sum
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sum <= '0;
      csum_bad <= 1'b0;
    end else if (take && state == TYPE) begin
      sum <= '0;
      csum_bad <= 1'b0;
    end else if (take && half && (state inside {COUNT, ADDR, DATA})) begin
      sum <= sum + byte_w;
    end else if (take && half && state == CSUM) begin
      csum_bad <= byte_w != ~sum;
    end
`else
  assign csum_bad = 1'b0;
`endif
endmodule

// File: tb/tb_srec_loader.sv
// tb_srec_loader: directed and randomized S-record streams checked against a record-level model.
module tb_srec_loader;
  localparam logic [31:0] OFS = 32'h100;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] char_in = 8'h0;
  logic char_valid = 1'b0;
  logic char_ready, mem_write, done, err;
  logic [31:0] mem_address, mem_data_in, entry_point;
  logic [1:0] mem_access_size, err_code;
  logic [15:0] rec_count;
  int total = 0, bad = 0, exp_cnt = 0;
  logic exp_err = 1'b0;
  logic [1:0] exp_code = 2'b00;
  logic [63:0] exp_q[$], obs_q[$];

  srec_loader #(.ADDR_W(32), .ADDR_OFFSET(OFS), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid), .char_ready(char_ready),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write(mem_write),
    .mem_access_size(mem_access_size), .entry_point(entry_point), .rec_count(rec_count),
    .done(done), .err(err), .err_code(err_code));

  always #5 clk = ~clk;
  always @(negedge clk) if (mem_write) obs_q.push_back({mem_address, mem_data_in});

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    char_in = c;
    char_valid = 1'b1;
    while (!char_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", n < 16, 1);
    @(posedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic settle();
    @(negedge clk);
    char_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic note_err(input logic [1:0] c);
    if (!exp_err) begin
      exp_err = 1'b1;
      exp_code = c;
    end
  endtask

  task automatic check_writes(input string tag);
    settle();
    chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) chk({tag, "_wr"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
    chk({tag, "_cnt"}, rec_count, exp_cnt);
    chk({tag, "_err"}, {err, err_code}, {exp_err, exp_code});
  endtask

  task automatic model_reset();
    obs_q.delete();
    exp_q.delete();
    exp_cnt = 0;
    exp_err = 1'b0;
    exp_code = 2'b00;
  endtask

  function automatic int alen(input int t);
    return (t == 0 || t == 1 || t == 5 || t == 9) ? 2 : (t == 2 || t == 8) ? 3 : 4;
  endfunction

  function automatic logic [31:0] trunc(input int t, input logic [31:0] a);
    int n;
    n = alen(t);
    return n == 4 ? a : n == 3 ? {8'h0, a[23:0]} : {16'h0, a[15:0]};
  endfunction

  function automatic string hx(input logic [7:0] b, input bit lc);
    return lc ? $sformatf("%02x", b) : $sformatf("%02X", b);
  endfunction

  function automatic string rec(input int t, input logic [31:0] a, input logic [7:0] d[$], input bit lc);
    int n;
    logic [7:0] s, b;
    string str;
    n = alen(t);
    b = 8'(n + d.size() + 1);
    s = b;
    str = $sformatf("S%0d%s", t, hx(b, lc));
    for (int i = n - 1; i >= 0; i--) begin
      b = a[8*i +: 8];
      s = s + b;
      str = {str, hx(b, lc)};
    end
    foreach (d[i]) begin
      s = s + d[i];
      str = {str, hx(d[i], lc)};
    end
    str = {str, hx(~s, lc)};
    if (lc) str = {str, "\r"};
    return {str, "\n"};
  endfunction

  task automatic add_writes(input int t, input logic [31:0] a, input logic [7:0] d[$]);
    foreach (d[k]) exp_q.push_back({trunc(t, a) + OFS + 32'(k), 24'h0, d[k]});
  endtask

  initial begin
    int rt, rn;
    logic [31:0] ra;
    logic [7:0] rd[$];
    repeat (2) @(negedge clk);
    chk("rst_addr", mem_address, 0);
    chk("rst_data", mem_data_in, 0);
    chk("rst_wr", mem_write, 0);
    chk("rst_entry", entry_point, 0);
    chk("rst_cnt", rec_count, 0);
    chk("rst_flags", {done, err, err_code}, 0);
    chk("rst_size", mem_access_size, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", char_ready, 1);
    send_str("S10500001234B4\n");
    exp_q.push_back({OFS, 32'h12});
    exp_q.push_back({OFS + 32'd1, 32'h34});
    exp_cnt++;
    check_writes("s1");
    send_str("S30980020000DEADBEEF3C\r\n");
    exp_q.push_back({32'h8002_0100, 32'hDE});
    exp_q.push_back({32'h8002_0101, 32'hAD});
    exp_q.push_back({32'h8002_0102, 32'hBE});
    exp_q.push_back({32'h8002_0103, 32'hEF});
    exp_cnt++;
    check_writes("s3");
    for (int r = 0; r < 24; r++) begin
      rt = (r == 3) ? 3 : $urandom_range(1, 3);
      ra = (r == 3) ? 32'hFFFF_FEFD : $urandom;
      rn = (r == 3) ? 6 : $urandom_range(0, 8);
      rd.delete();
      for (int k = 0; k < rn; k++) rd.push_back(8'($urandom));
      send_str(rec(rt, ra, rd, r[0]));
      add_writes(rt, ra, rd);
      exp_cnt++;
      check_writes("rnd");
    end
    send_str("S10500001234B5\n");
    exp_q.push_back({OFS, 32'h12});
    exp_q.push_back({OFS + 32'd1, 32'h34});
`ifdef SREC_CHECKSUM_EN
    note_err(2'b11);
`else
    exp_cnt++;
`endif
    check_writes("badsum");
    send_str("S1050000G234B4\n");
    note_err(2'b01);
    check_writes("badchar");
    send_str("S10500001234B4\n");
    exp_q.push_back({OFS, 32'h12});
    exp_q.push_back({OFS + 32'd1, 32'h34});
    exp_cnt++;
    check_writes("recover");
    send_str("S1020000FD\n");
    note_err(2'b10);
    check_writes("badcount");
    send_str("S105000012\n");
    exp_q.push_back({OFS, 32'h12});
    note_err(2'b10);
    check_writes("early_lf");
    send_str("S403000000FC\n");
    note_err(2'b01);
    check_writes("s4");
    send_str("X\n");
    note_err(2'b01);
    check_writes("junk");
    send_str("S00600004844521B\n");
    check_writes("s0");
    send_str("S7058002000078\n");
    check_writes("s7");
    chk("s7_entry", entry_point, 32'h8002_0000);
    chk("s7_done", done, 1);
    chk("s7_ready", char_ready, 0);
    reset = 1'b1;
    #1;
    chk("rst2_entry", entry_point, 0);
    chk("rst2_flags", {done, err, err_code}, 0);
    chk("rst2_cnt", rec_count, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    send_str("S10500001");
    send("2");
    #1;
    chk("mid_wr", mem_write, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_wr", mem_write, 0);
    chk("mid_rst_addr", mem_address, 0);
    chk("mid_rst_data", mem_data_in, 0);
    char_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_writes("mid_rst");
    send_str("S30980020000DEADBEEF3C\r\n");
    exp_q.push_back({32'h8002_0100, 32'hDE});
    exp_q.push_back({32'h8002_0101, 32'hAD});
    exp_q.push_back({32'h8002_0102, 32'hBE});
    exp_q.push_back({32'h8002_0103, 32'hEF});
    exp_cnt++;
    check_writes("s3b");
    send_str("S9031234B6\n");
    check_writes("s9");
    chk("s9_entry", entry_point, 32'h0000_1234);
    chk("s9_done", done, 1);
    chk("end_size", mem_access_size, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
